// File: rtl/disp_pkg.sv
// disp_pkg: shared state encodings, ring constants and ring index helper for disp_scroller
package disp_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCROLL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] BLANK_CHAR = 8'h00;
  localparam int RING_LEN = 12;
  localparam logic [3:0] LAST_POS = 4'(RING_LEN - 1);
  function automatic logic [3:0] ring_idx(input logic [3:0] p, input logic [1:0] k);
    logic [4:0] s;
    s = {1'b0, p} + {3'b000, k};
    return (s >= 5'(RING_LEN)) ? 4'(s - 5'(RING_LEN)) : s[3:0];
  endfunction
endpackage

// File: rtl/disp_scroller_hex_to_ascii.sv
// hex_to_ascii: nibble to uppercase ASCII hex digit; ports i_nib (4b in), o_char (8b out)
module hex_to_ascii (
  input  logic [3:0] i_nib,
  input  logic [7:0] o_char_unused_guard,
  output logic [7:0] o_char
);
  logic [7:0] w_unused;
  assign w_unused = o_char_unused_guard;
  assign o_char = (i_nib < 4'd10) ? {4'h3, i_nib} : 8'h37 + {4'h0, i_nib};
endmodule

// File: rtl/disp_scroller.sv
// disp_scroller: scrolls a 4-char window over 8 hex chars + 4 blanks; ports clk, reset, load, data_in, pause, one_shot -> disp_num, busy
module disp_scroller
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int TICK_W = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        pause,
  input  logic        one_shot,
  output logic [31:0] disp_num,
  output logic        busy
);
  logic [31:0] r_data;
  logic r_os;
  logic [3:0] r_pos;
  logic [TICK_W-1:0] r_tick;
  logic [1:0] r_state;
  logic [7:0] w_ch [RING_LEN];
  logic w_show;
  logic w_term;
  genvar g;
  for (g = 0; g < 8; g++) begin : g_hex
    hex_to_ascii u_hex (
      .i_nib(r_data[31-4*g -: 4]),
      .o_char_unused_guard(BLANK_CHAR),
      .o_char(w_ch[g])
    );
  end
  for (g = 8; g < RING_LEN; g++) begin : g_blank
    assign w_ch[g] = BLANK_CHAR;
  end
  // Invalid encodings show blank like IDLE
  assign w_show = (r_state == ST_SCROLL) || (r_state == ST_DONE);
  assign w_term = r_tick == TICK_W'(TICK_DIV - 1);
  assign busy = r_state == ST_SCROLL;
  assign disp_num = w_show ? {w_ch[ring_idx(r_pos, 2'd0)], w_ch[ring_idx(r_pos, 2'd1)],
                              w_ch[ring_idx(r_pos, 2'd2)], w_ch[ring_idx(r_pos, 2'd3)]} : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data <= '0;
      r_os <= 1'b0;
      r_pos <= '0;
      r_tick <= '0;
    end else if (load) begin
      r_state <= ST_SCROLL;
      r_data <= data_in;
      r_os <= one_shot;
      r_pos <= '0;
      r_tick <= '0;
    end else if (r_state == ST_SCROLL) begin
      if (!pause) begin
        if (w_term) begin
          r_tick <= '0;
          if (r_pos == LAST_POS) begin
            r_pos <= '0;
            if (r_os) r_state <= ST_DONE;
          end else begin
            r_pos <= r_pos + 4'd1;
          end
        end else begin
          r_tick <= r_tick + TICK_W'(1);
        end
      end
    end else if (r_state != ST_DONE) begin
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_disp_scroller.sv
// tb_disp_scroller: scoreboard bench for disp_scroller against a cycle-count reference model
module tb_disp_scroller;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic pause = 1'b0;
  logic one_shot = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] disp_num;
  logic busy;
  typedef struct {
    logic [31:0] d;
    logic b;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_mode = 0;
  logic [31:0] m_data = '0;
  logic m_os = 1'b0;
  int m_n = 0;
  always #5 clk = ~clk;
  disp_scroller #(.TICK_DIV(TD), .TICK_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .data_in(data_in),
    .pause(pause),
    .one_shot(one_shot),
    .disp_num(disp_num),
    .busy(busy)
  );
  function automatic logic [7:0] char_at(input logic [31:0] d, input int i);
    int nib;
    if (i >= 8) return 8'h00;
    nib = int'((d >> (28 - 4 * i)) & 32'hF);
    return (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
  endfunction
  function automatic logic [31:0] window(input logic [31:0] d, input int p);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w = {w[23:0], char_at(d, (p + k) % 12)};
    return w;
  endfunction
  function automatic int m_pos();
    return (m_n / TD) % 12;
  endfunction
  task automatic cycle(input logic r, input logic l, input logic [31:0] d, input logic p, input logic o);
    exp_t e;
    reset = r;
    load = l;
    data_in = d;
    pause = p;
    one_shot = o;
    @(posedge clk);
    if (r) begin
      m_mode = 0;
      m_n = 0;
      m_data = '0;
    end else if (l) begin
      m_mode = 1;
      m_data = d;
      m_os = o;
      m_n = 0;
    end else if (m_mode == 1 && !p) begin
      m_n++;
      if (m_os && m_n >= 12 * TD) m_mode = 2;
    end
    e.d = (m_mode == 0) ? 32'h0 : window(m_data, (m_mode == 2) ? 0 : m_pos());
    e.b = m_mode == 1;
    q.push_back(e);
    #1;
    reset = 1'b0;
    load = 1'b0;
  endtask
  task automatic run(input int k, input logic p);
    repeat (k) cycle(1'b0, 1'b0, 32'h0, p, 1'b0);
  endtask
  task automatic run_until(input int p);
    int g;
    g = 0;
    while (!(m_mode == 1 && m_pos() == p && m_n % TD == 0) && g < 200) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      g++;
    end
    n_chk++;
    if (g >= 200) begin
      n_fail++;
      $display("FAIL run_until: pos %0d not reached, model pos %0d", p, m_pos());
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] e, input logic eb);
    @(negedge clk);
    n_chk++;
    if (disp_num !== e || busy !== eb) begin
      n_fail++;
      $display("FAIL %s: disp_num=%h busy=%b, required disp_num=%h busy=%b", nm, disp_num, busy, e, eb);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (disp_num !== e.d || busy !== e.b) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: disp_num=%h busy=%b, required disp_num=%h busy=%b",
                 $time, disp_num, busy, e.d, e.b);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset", 32'h0, 1'b0);
    run(20, 1'b0);
    chk("idle_hold", 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 1'b0);
    chk("load_pos0", 32'h31323334, 1'b1);
    run(4, 1'b0);
    chk("pos1", 32'h32333441, 1'b1);
    run_until(2);
    run(1, 1'b0);
    run(10, 1'b1);
    chk("pause_frozen", 32'h33344142, 1'b1);
    run(2, 1'b0);
    chk("pause_resume_hold", 32'h33344142, 1'b1);
    run(1, 1'b0);
    chk("pause_resume_step", 32'h34414243, 1'b1);
    run_until(4);
    chk("pos4", 32'h41424344, 1'b1);
    run_until(8);
    chk("pos8_blank", 32'h00000000, 1'b1);
    run_until(11);
    chk("pos11", 32'h00313233, 1'b1);
    run_until(0);
    chk("wrap_loop", 32'h31323334, 1'b1);
    run_until(5);
    run(3, 1'b0);
    cycle(1'b0, 1'b1, 32'h00000F0F, 1'b0, 1'b0);
    chk("load_on_tick", 32'h30303030, 1'b1);
    run(4, 1'b0);
    chk("f0f_pos1", 32'h30303030, 1'b1);
    run(4, 1'b0);
    chk("f0f_pos2", 32'h30303046, 1'b1);
    run_until(7);
    run(2, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("reset_mid", 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'hCAFE0123, 1'b0, 1'b0);
    chk("reload", 32'h43414645, 1'b1);
    cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("oneshot_load", 32'h44454144, 1'b1);
    run(47, 1'b0);
    chk("oneshot_pos11", 32'h00444541, 1'b1);
    run(1, 1'b0);
    chk("done", 32'h44454144, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 32'h0, 1'($urandom % 2), 1'b0);
    chk("done_hold", 32'h44454144, 1'b0);
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 14) == 0, $urandom,
            $urandom_range(0, 3) == 0, 1'($urandom % 2));
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
